// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and ALU opcode constants.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11001;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier for the control unit sequencer.
// mul/div are recognised only when CU_MULDIV_EN is defined; otherwise they fall to nop.
module cu_decode
    import cpu_pkg::*;
(
    input  logic [4:0] op,
    output logic       r_alu,
    output logic       imm_alu,
    output logic       unary,
    output logic       muldiv,
    output logic       nop,
    output logic       halt
);

    always_comb begin
        r_alu   = (op >= OP_ADD) && (op <= OP_ROL);
        imm_alu = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
        unary   = (op == OP_NEG) || (op == OP_NOT);
`ifdef CU_MULDIV_EN
        muldiv  = (op == OP_MUL) || (op == OP_DIV);
`else
        muldiv  = 1'b0;
`endif
        halt    = (op == OP_HALT);
        // Anything not claimed above, including 11000, is a nop.
        nop     = !(r_alu || imm_alu || unary || muldiv || halt);
    end

endmodule

// File: rtl/control_unit.sv
// Moore-style instruction sequencer: fetch (T0-T2), execute (T3-T6), HALT.
// Optional mul/div execution sequence is enabled by defining CU_MULDIV_EN.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  opcode,
    output logic        Run
);

    state_t     state_reg;
    logic [4:0] op_field;
    logic       is_r_alu;
    logic       is_imm_alu;
    logic       is_unary;
    logic       is_muldiv;
    logic       is_nop;
    logic       is_halt;
    logic       unused_ir;

    assign op_field  = IR[31:27];
    // Operand fields are consumed by the select/encode logic, not here.
    assign unused_ir = ^IR[26:0];

    cu_decode u_decode (
        .op      (op_field),
        .r_alu   (is_r_alu),
        .imm_alu (is_imm_alu),
        .unary   (is_unary),
        .muldiv  (is_muldiv),
        .nop     (is_nop),
        .halt    (is_halt)
    );

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_reg <= ST_RST;
        end else begin
            case (state_reg)
                ST_RST:  state_reg <= ST_T0;
                ST_T0:   state_reg <= Stop ? ST_HALT : ST_T1;
                ST_T1:   state_reg <= ST_T2;
                ST_T2: begin
                    if (is_halt)
                        state_reg <= ST_HALT;
                    else if (is_nop)
                        state_reg <= ST_T0;
                    else
                        state_reg <= ST_T3;
                end
                ST_T3:   state_reg <= ST_T4;
                ST_T4:   state_reg <= is_unary ? ST_T0 : ST_T5;
                ST_T5:   state_reg <= is_muldiv ? ST_T6 : ST_T0;
                ST_T6:   state_reg <= ST_T0;
                ST_HALT: state_reg <= ST_HALT;
                default: state_reg <= ST_RST;
            endcase
        end
    end

    // Enables decode straight from the state register, so an asynchronous
    // clear zeroes every output as soon as the state falls back to RST.
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        opcode   = OP_NONE;
        Run      = 1'b0;
        case (state_reg)
            ST_T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                Run  = 1'b1;
                Rout = 1'b1;
                if (is_unary) begin
                    Grb    = 1'b1;
                    Zin    = 1'b1;
                    opcode = op_field;
                end else if (is_muldiv) begin
                    Gra = 1'b1;
                    Yin = 1'b1;
                end else begin
                    Grb = 1'b1;
                    Yin = 1'b1;
                end
            end
            ST_T4: begin
                Run = 1'b1;
                if (is_unary) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (is_muldiv) begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    opcode = op_field;
                end else if (is_imm_alu) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    opcode = op_field;
                end else begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    opcode = op_field;
                end
            end
            ST_T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            ST_T6: begin
                Run      = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks fetch/execute sequences and checks every enable per cycle.
// Builds and checks either way for CU_MULDIV_EN.
`timescale 1ns/1ps
module tb_control_unit;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run;
    logic [4:0]  opcode;

    int n_checks = 0;
    int n_errors = 0;

    // Bit masks for the packed control word observed below.
    localparam logic [22:0] M_PCOUT   = 23'h1 << 22;
    localparam logic [22:0] M_ZHIGH   = 23'h1 << 21;
    localparam logic [22:0] M_ZLOW    = 23'h1 << 20;
    localparam logic [22:0] M_MDROUT  = 23'h1 << 19;
    localparam logic [22:0] M_HIOUT   = 23'h1 << 18;
    localparam logic [22:0] M_LOOUT   = 23'h1 << 17;
    localparam logic [22:0] M_COUT    = 23'h1 << 16;
    localparam logic [22:0] M_PCIN    = 23'h1 << 15;
    localparam logic [22:0] M_MARIN   = 23'h1 << 14;
    localparam logic [22:0] M_MDRIN   = 23'h1 << 13;
    localparam logic [22:0] M_IRIN    = 23'h1 << 12;
    localparam logic [22:0] M_YIN     = 23'h1 << 11;
    localparam logic [22:0] M_ZIN     = 23'h1 << 10;
    localparam logic [22:0] M_HIIN    = 23'h1 << 9;
    localparam logic [22:0] M_LOIN    = 23'h1 << 8;
    localparam logic [22:0] M_INCPC   = 23'h1 << 7;
    localparam logic [22:0] M_READ    = 23'h1 << 6;
    localparam logic [22:0] M_GRA     = 23'h1 << 5;
    localparam logic [22:0] M_GRB     = 23'h1 << 4;
    localparam logic [22:0] M_GRC     = 23'h1 << 3;
    localparam logic [22:0] M_RIN     = 23'h1 << 2;
    localparam logic [22:0] M_ROUT    = 23'h1 << 1;
    localparam logic [22:0] M_RUN     = 23'h1;

    localparam logic [22:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
    localparam logic [22:0] E_T1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [22:0] E_T2 = M_MDROUT | M_IRIN | M_RUN;

    logic [22:0] ctl;
    assign ctl = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, PCin, MARin,
                  MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc,
                  Rin, Rout, Run};

    control_unit dut (
        .Clock    (Clock),
        .clear    (clear),
        .IR       (IR),
        .Stop     (Stop),
        .PCout    (PCout),
        .Zhighout (Zhighout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .HIout    (HIout),
        .LOout    (LOout),
        .Cout     (Cout),
        .PCin     (PCin),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .HIin     (HIin),
        .LOin     (LOin),
        .IncPC    (IncPC),
        .Read     (Read),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .opcode   (opcode),
        .Run      (Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Called at a falling edge: checks the current state's outputs, then advances one cycle.
    task automatic step(input string tag, input logic [22:0] ectl, input logic [4:0] eopc);
        check_eq({tag, ".ctl"}, {9'd0, ctl}, {9'd0, ectl});
        check_eq({tag, ".opc"}, {27'd0, opcode}, {27'd0, eopc});
        @(negedge Clock);
    endtask

    task automatic fetch(input string tag);
        step({tag, ".T0"}, E_T0, 5'b00000);
        step({tag, ".T1"}, E_T1, 5'b00000);
        step({tag, ".T2"}, E_T2, 5'b00000);
    endtask

    initial begin
        clear = 1'b0;
        IR    = 32'h0;
        Stop  = 1'b0;
        repeat (2) @(negedge Clock);
        check_eq("reset.ctl", {9'd0, ctl}, 32'h0);
        check_eq("reset.opc", {27'd0, opcode}, 32'h0);
        clear = 1'b1;
        step("rst_released", 23'h0, 5'b00000);

        // and r-format: T0 returns at cycle 7
        IR = 32'h28918000;
        fetch("and");
        step("and.T3", M_GRB | M_ROUT | M_YIN | M_RUN, 5'b00000);
        step("and.T4", M_GRC | M_ROUT | M_ZIN | M_RUN, 5'b00101);
        step("and.T5", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'b00000);

        // addi: Cout replaces Grc/Rout in T4
        IR = 32'h59000000;
        fetch("addi");
        step("addi.T3", M_GRB | M_ROUT | M_YIN | M_RUN, 5'b00000);
        step("addi.T4", M_COUT | M_ZIN | M_RUN, 5'b01011);
        step("addi.T5", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'b00000);

        // mul: full sequence or nop depending on build
        IR = 32'h71180000;
        fetch("mul");
`ifdef CU_MULDIV_EN
        step("mul.T3", M_GRA | M_ROUT | M_YIN | M_RUN, 5'b00000);
        step("mul.T4", M_GRB | M_ROUT | M_ZIN | M_RUN, 5'b01110);
        step("mul.T5", M_ZLOW | M_LOIN | M_RUN, 5'b00000);
        step("mul.T6", M_ZHIGH | M_HIIN | M_RUN, 5'b00000);
`endif

        // neg: Stop raised in T1 must be ignored
        IR = 32'h80000000;
        step("neg.T0", E_T0, 5'b00000);
        Stop = 1'b1;
        step("neg.T1", E_T1, 5'b00000);
        Stop = 1'b0;
        step("neg.T2", E_T2, 5'b00000);
        step("neg.T3", M_GRB | M_ROUT | M_ZIN | M_RUN, 5'b10000);
        step("neg.T4", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'b00000);

        // 11000 is nop: T2 straight back to T0
        IR = 32'hC0000000;
        fetch("nop");

        // clear pulsed during T4 of an or
        IR = 32'h30000000;
        fetch("or");
        step("or.T3", M_GRB | M_ROUT | M_YIN | M_RUN, 5'b00000);
        check_eq("or.T4.ctl", {9'd0, ctl}, {9'd0, M_GRC | M_ROUT | M_ZIN | M_RUN});
        #2 clear = 1'b0;
        #1;
        check_eq("midclear.ctl", {9'd0, ctl}, 32'h0);
        check_eq("midclear.opc", {27'd0, opcode}, 32'h0);
        #1 clear = 1'b1;
        @(negedge Clock);

        // Stop in T0: T0 outputs still driven, then HALT
        IR = 32'h18000000;
        Stop = 1'b1;
        step("stop.T0", E_T0, 5'b00000);
        Stop = 1'b0;
        step("stop.HALT", 23'h0, 5'b00000);
        step("stop.HALT_held", 23'h0, 5'b00000);

        // halt instruction after a fresh reset
        clear = 1'b0;
        @(negedge Clock);
        clear = 1'b1;
        @(negedge Clock);
        IR = 32'hC8000000;
        fetch("halt");
        step("halt.HALT", 23'h0, 5'b00000);
        step("halt.HALT_held", 23'h0, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port IR, input, 32 bits: instruction register contents; opcode field IR[31:27].
REQ-004 SHALL have port Stop, input, 1 bit: halt request, sampled only in T0.
REQ-005 SHALL have ports PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, output, 1 bit each: bus-driver enables to the datapath.
REQ-006 SHALL have ports PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, output, 1 bit each: register load enables.
REQ-007 SHALL have ports IncPC, Read, output, 1 bit each: PC increment via ALU; memory read into MDR.
REQ-008 SHALL have ports Gra, Grb, Grc, Rin, Rout, output, 1 bit each: register-field selects and general-register load/drive to the select/encode logic.
REQ-009 SHALL have port opcode, output, 5 bits: ALU operation code.
REQ-010 SHALL have port Run, output, 1 bit: high while the sequencer is executing.

Function
REQ-011 SHALL be a Moore FSM; states: RST, T0, T1, T2, T3, T4, T5, T6, HALT; every output is a function of state and IR[31:27] only.
REQ-012 SHALL drive, in T0: PCout, MARin, IncPC, Zin.
REQ-013 SHALL drive, in T1: Zlowout, PCin, Read, MDRin.
REQ-014 SHALL drive, in T2: MDRout, IRin.
REQ-015 SHALL use opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, halt 11001; every other code (including 11000) is nop.
REQ-016 SHALL execute R-format ALU ops (00011-01010) as: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin with opcode=IR[31:27]; T5 Zlowout,Gra,Rin; then T0.
REQ-017 SHALL execute immediate ops (addi/andi/ori) as the REQ-016 sequence, except T4 drives Cout in place of Grc,Rout.
REQ-018 SHALL execute neg/not as: T3 Grb,Rout,Zin with opcode set; T4 Zlowout,Gra,Rin; then T0.
REQ-019 SHALL execute mul/div as: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin with opcode set; T5 Zlowout,LOin; T6 Zhighout,HIin; then T0.
REQ-020 SHALL go from T2 to T0 for nop.
REQ-021 SHALL go from T2 to HALT for halt; HALT is held with all outputs 0 and Run=0 until clear.
REQ-022 SHALL go from T0 to HALT at the next edge when Stop=1 in T0, with T0 outputs still driven during that cycle; Stop in any other state is ignored.
REQ-023 SHALL set opcode=00000 in every state except the ALU-compute state of REQ-016 to REQ-019.
REQ-024 SHALL assert each enable for exactly one full clock cycle per state visit; no enable is combinationally dependent on Clock.
REQ-025 SHALL complete a full instruction in 6 cycles for R/immediate ops, 5 for neg/not, 7 for mul/div and 3 for nop.

Reset
REQ-026 SHALL, while clear=0 (including mid-instruction), force state RST and all outputs to 0 (opcode=00000, Run=0), independent of Clock.
REQ-027 SHALL go from RST to T0 at the first rising edge with clear=1; Run=1 in T0 through T6.

Configuration
REQ-028 SHALL, when CU_MULDIV_EN is defined, implement the mul/div sequence of REQ-019; when it is undefined, treat opcodes 01110 and 01111 as nop, and T6 becomes unreachable.

Structure
REQ-029 SHALL take opcode constants and state encodings from shared package cpu_pkg.
REQ-030 SHALL place opcode classification (r_alu, imm_alu, unary, muldiv, nop, halt) in combinational sub-module cu_decode.

Verification
REQ-031 SHALL verify: clear low 2 cycles, then high -> RST, then T0 with PCout=MARin=IncPC=Zin=1, Run=1.
REQ-032 SHALL verify: IR=0x28918000 (and) -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with opcode=00101, T5 Zlowout/Gra/Rin, T0 at cycle 7.
REQ-033 SHALL verify: IR=0x59000000 (addi) -> T4 drives Cout=1, Grc=0, opcode=01011.
REQ-034 SHALL verify: IR=0x71180000 (mul) with CU_MULDIV_EN defined -> T5 LOin=1, T6 HIin=1; with it undefined -> T2 then T0.
REQ-035 SHALL verify: Stop=1 during T0 -> HALT with Run=0 after that edge; IR=0xC8000000 (halt) -> HALT after T2.
REQ-036 SHALL verify: clear pulsed low during T4 -> all outputs 0 immediately; fetch restarts at T0.
